memcpy_engine: RTL and testbench
================================

# memcpy_engine

Word-granular block-copy engine that drives the two ports of the data memory: port 1 is its read port and port 2 is its write port. Software loads source, destination and length, pulses `start`, and the engine moves one 32-bit word per clock until `done`. It sits beside the load/store stage as a second master of the data memory.

## Interface
Parameters:
- `DEPTH`, 64, number of 32-bit words in the attached data memory. Used only for the range check.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset, sampled on posedge `clk`.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `src` in 32: source byte address; bits [1:0] ignored (forced 0).
- `dst` in 32: destination byte address; bits [1:0] ignored.
- `len` in 32: number of words to copy.
- `busy` out 1: engine owns memory ports (COPY or DONE).
- `done` out 1: one-cycle completion pulse.
- `err` out 1: range error flag; valid while `done`=1, held until next accepted `start`.
- `we1` out 1: port-1 write enable; constant 0.
- `we2` out 1: port-2 write enable.
- `a1` out 32: read address to memory port 1.
- `a2` out 32: write address to memory port 2.
- `wd1` out 32: constant 0.
- `wd2` out 32: write data; combinationally equal to `rd1`.
- `rd1` in 32: asynchronous read data from port 1.
- `rd2` in 32: unused.

## Operation
- States: IDLE, COPY, DONE.
- IDLE, `start`=1:
  - latch `src[31:2]`, `dst[31:2]` and `len`; clear `err`.
  - If `len`=0, go to DONE with `err`=0.
  - Else compute the range check in 33-bit arithmetic: `src_word+len > DEPTH` or `dst_word+len > DEPTH`. If it fails, go to DONE with `err`=1 and perform no writes.
  - Otherwise go to COPY.
- COPY:
  - each cycle, `a1`={rptr,2'b00}, `a2`={wptr,2'b00}, `we2`=1, `wd2`=`rd1`.
  - Step both pointers and decrement the remaining count by 1.
  - When remaining=1, go to DONE next edge.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Copy direction: ascending by default (pointers start at src/dst and increment). See Configuration.
- `src`==`dst`: copy proceeds normally; writes rewrite identical data.
- `start` outside IDLE is ignored and not queued.
- In IDLE and DONE: `we2`=0, and `a1`/`a2` hold the last driven value. Both are 0 after reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `we1`=0, `we2`=0, `a1`=0, `a2`=0, `wd1`=0, pointers and count 0.
- `start` sampled at edge N. COPY cycles are N+1 through N+len, and `done` is high during cycle N+len+1. Total latency from `start` to `done` is len+1 cycles.
- `len`=0 or range error: `done` is high in cycle N+1.
- Throughput: 1 word per cycle. The read is combinational within the cycle; the memory commits the write on the negedge of that same cycle.
- `busy` is high from cycle N+1 through the `done` cycle inclusive.
- Reset asserted mid-COPY: at the next posedge the engine returns to IDLE with all outputs at reset values.
  - Words already written remain in memory; no further writes occur.
  - `done` is not pulsed.
- `done` and the next accepted `start` cannot overlap. The earliest new `start` is sampled in the IDLE cycle after `done`.

## Configuration
- `MEMCPY_OVERLAP_EN` defined: if `dst_word > src_word` and `dst_word < src_word+len`, the engine copies descending.
  - Pointers start at src+len-1 and dst+len-1 and decrement.
  - Result is memmove-correct for any overlap.
- Undefined: always ascending. Forward-overlapping regions are propagated (smeared), and this is the specified behaviour.

## Test plan
- Basic copy: preload words 0..3 with 0x11,0x22,0x33,0x44; src=0x00, dst=0x40, len=4, pulse `start` -> words 16..19 = 0x11..0x44, `done` 5 cycles after `start`, `err`=0, `we2` high for exactly 4 cycles.
- Zero length: len=0 -> `done` the next cycle, `err`=0, `we2` never asserted, memory unchanged.
- Range error: src=0xF8 (word 62), dst=0x00, len=4, DEPTH=64 -> `done` next cycle with `err`=1, no writes.
- Overlap: words 0..4 = 1,2,3,4,5; src=0x00, dst=0x04, len=4 -> with `MEMCPY_OVERLAP_EN` words 1..4 = 1,2,3,4; without it words 1..4 = 1,1,1,1.
- Reset mid-copy: len=8, drop `rst` during the 3rd COPY cycle -> exactly 3 destination words written, `busy`=0 and `done`=0 after that edge, remaining destination words untouched.
- Start while busy: second `start` pulse during COPY with different src -> ignored; only the first copy's data lands, and there is a single `done` pulse.

Source files
------------

// File: rtl/memcpy_engine_if.sv
// Control and data-memory port bundle for memcpy_engine.
// The master modport is the engine side; the slave modport is the memory/software side.
interface memcpy_engine_if;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        we1;
    logic        we2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    modport master (
        input  start, src, dst, len, rd1, rd2,
        output busy, done, err, we1, we2, a1, a2, wd1, wd2
    );

    modport slave (
        output start, src, dst, len, rd1, rd2,
        input  busy, done, err, we1, we2, a1, a2, wd1, wd2
    );
endinterface

// File: rtl/memcpy_engine.sv
// Word-granular block copy engine: reads data-memory port 1 and writes port 2, one word per clock.
// Optional macro MEMCPY_OVERLAP_EN selects a descending copy for forward-overlapping regions.
module memcpy_engine #(
    parameter int unsigned DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    memcpy_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

    state_e      state_q, state_d;
    logic [29:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] a1_q, a1_d, a2_q, a2_d;
    logic        err_q, err_d;
    logic        desc_q, desc_d;

    logic [29:0] src_w, dst_w;
    logic [32:0] src_end, dst_end;
    logic        range_bad, overlap;
    logic        we2_c, done_c;
    logic [31:0] a1_c, a2_c;
    logic        unused_ok;

    assign src_w     = bus.src[31:2];
    assign dst_w     = bus.dst[31:2];
    // 33-bit sums so a huge len cannot wrap past the bound
    assign src_end   = {3'b0, src_w} + {1'b0, bus.len};
    assign dst_end   = {3'b0, dst_w} + {1'b0, bus.len};
    assign range_bad = (src_end > 33'(DEPTH)) || (dst_end > 33'(DEPTH));

`ifdef MEMCPY_OVERLAP_EN
    assign overlap = (dst_w > src_w) && ({3'b0, dst_w} < src_end);
`else
    assign overlap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        err_d   = err_q;
        desc_d  = desc_q;
        we2_c   = 1'b0;
        done_c  = 1'b0;
        a1_c    = a1_q;
        a2_c    = a2_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d  = 1'b0;
                    desc_d = 1'b0;
                    rptr_d = src_w;
                    wptr_d = dst_w;
                    cnt_d  = bus.len;
                    if (bus.len == 32'd0) begin
                        state_d = DONE;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = COPY;
                        // Range check passed, so len fits in the 30-bit pointer width
                        if (overlap) begin
                            desc_d = 1'b1;
                            rptr_d = src_w + bus.len[29:0] - 30'd1;
                            wptr_d = dst_w + bus.len[29:0] - 30'd1;
                        end
                    end
                end
            end
            COPY: begin
                a1_c   = {rptr_q, 2'b00};
                a2_c   = {wptr_q, 2'b00};
                a1_d   = a1_c;
                a2_d   = a2_c;
                we2_c  = 1'b1;
                rptr_d = desc_q ? rptr_q - 30'd1 : rptr_q + 30'd1;
                wptr_d = desc_q ? wptr_q - 30'd1 : wptr_q + 30'd1;
                cnt_d  = cnt_q - 32'd1;
                if (cnt_q == 32'd1) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            err_q   <= 1'b0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            err_q   <= err_d;
            desc_q  <= desc_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_c;
    assign bus.err  = err_q;
    assign bus.we1  = 1'b0;
    assign bus.we2  = we2_c;
    assign bus.a1   = a1_c;
    assign bus.a2   = a2_c;
    assign bus.wd1  = 32'd0;
    assign bus.wd2  = bus.rd1;

    assign unused_ok = ^{bus.rd2, bus.src[1:0], bus.dst[1:0]};
endmodule

// File: tb/tb_memcpy_engine.sv
// Directed bench for memcpy_engine with a 64-word behavioural data memory.
module tb_memcpy_engine;
    logic clk;
    logic rst;
    memcpy_engine_if ifc();

    memcpy_engine #(.DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic        clr, ld;
    logic [5:0]  ld_a;
    logic [31:0] ld_d;

    // Memory commits on the negedge; port-1 read is combinational
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (ld) begin
            mem[ld_a] <= ld_d;
        end else if (ifc.we2) begin
            mem[ifc.a2[7:2]] <= ifc.wd2;
        end
    end
    assign ifc.rd1 = mem[ifc.a1[7:2]];
    assign ifc.rd2 = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_clear();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        ld_a = a;
        ld_d = d;
        ld   = 1'b1;
        @(negedge clk); #1;
        ld   = 1'b0;
    endtask

    // Pulses start, then follows the job; returns in the done cycle (cycle index relative to start edge)
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                       output int dcyc, output int wcnt, output logic e);
        dcyc = -1;
        wcnt = 0;
        e    = 1'b0;
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.src   = s;
        ifc.dst   = d;
        ifc.len   = l;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            if (ifc.we2) wcnt++;
            if (ifc.done) begin
                dcyc = c;
                e    = ifc.err;
            end
            if (dcyc < 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    int   dcyc, wcnt, ndone;
    logic e;

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        ld = 1'b0;
        ld_a = '0;
        ld_d = '0;
        ifc.start = 1'b0;
        ifc.src = '0;
        ifc.dst = '0;
        ifc.len = '0;
        mem_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
        chk("rst_done", {31'b0, ifc.done}, 32'd0);
        chk("rst_err",  {31'b0, ifc.err},  32'd0);
        chk("rst_we1",  {31'b0, ifc.we1},  32'd0);
        chk("rst_we2",  {31'b0, ifc.we2},  32'd0);
        chk("rst_a1",   ifc.a1,  32'd0);
        chk("rst_a2",   ifc.a2,  32'd0);
        chk("rst_wd1",  ifc.wd1, 32'd0);
        rst = 1'b1;

        // Basic ascending copy
        poke(6'd0, 32'h11); poke(6'd1, 32'h22); poke(6'd2, 32'h33); poke(6'd3, 32'h44);
        run(32'h00, 32'h40, 32'd4, dcyc, wcnt, e);
        chk("basic_done_cyc", dcyc, 32'd5);
        chk("basic_we2_cnt",  wcnt, 32'd4);
        chk("basic_err",      {31'b0, e}, 32'd0);
        chk("basic_busy_done", {31'b0, ifc.busy}, 32'd1);
        chk("basic_a1_hold",  ifc.a1, 32'h0C);
        chk("basic_a2_hold",  ifc.a2, 32'h4C);
        @(posedge clk); #1;
        chk("basic_w16", mem[16], 32'h11);
        chk("basic_w17", mem[17], 32'h22);
        chk("basic_w18", mem[18], 32'h33);
        chk("basic_w19", mem[19], 32'h44);
        chk("basic_idle_busy", {31'b0, ifc.busy}, 32'd0);

        // Zero length
        run(32'h00, 32'h80, 32'd0, dcyc, wcnt, e);
        chk("zero_done_cyc", dcyc, 32'd1);
        chk("zero_we2_cnt",  wcnt, 32'd0);
        chk("zero_err",      {31'b0, e}, 32'd0);
        chk("zero_w32",      mem[32], 32'd0);

        // Range error: source runs past word 63
        run(32'hF8, 32'h00, 32'd4, dcyc, wcnt, e);
        chk("range_done_cyc", dcyc, 32'd1);
        chk("range_we2_cnt",  wcnt, 32'd0);
        chk("range_err",      {31'b0, e}, 32'd1);
        @(posedge clk); #1;
        chk("range_err_held", {31'b0, ifc.err}, 32'd1);
        chk("range_w0",       mem[0], 32'h11);

        // Forward overlap by one word
        mem_clear();
        for (int i = 0; i < 5; i++) poke(6'(i), 32'(i + 1));
        run(32'h00, 32'h04, 32'd4, dcyc, wcnt, e);
        chk("ovl_done_cyc", dcyc, 32'd5);
        chk("ovl_err_clr",  {31'b0, e}, 32'd0);
        @(posedge clk); #1;
        chk("ovl_w0", mem[0], 32'd1);
`ifdef MEMCPY_OVERLAP_EN
        chk("ovl_w1", mem[1], 32'd1);
        chk("ovl_w2", mem[2], 32'd2);
        chk("ovl_w3", mem[3], 32'd3);
        chk("ovl_w4", mem[4], 32'd4);
`else
        chk("ovl_w1", mem[1], 32'd1);
        chk("ovl_w2", mem[2], 32'd1);
        chk("ovl_w3", mem[3], 32'd1);
        chk("ovl_w4", mem[4], 32'd1);
`endif

        // Reset asserted during the third COPY cycle
        mem_clear();
        for (int i = 0; i < 8; i++) poke(6'(i), 32'hA0 + 32'(i));
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.src = 32'h00; ifc.dst = 32'h80; ifc.len = 32'd8;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", {31'b0, ifc.busy}, 32'd0);
        chk("mrst_done", {31'b0, ifc.done}, 32'd0);
        chk("mrst_we2",  {31'b0, ifc.we2},  32'd0);
        chk("mrst_a1",   ifc.a1, 32'd0);
        chk("mrst_a2",   ifc.a2, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_w32", mem[32], 32'hA0);
        chk("mrst_w33", mem[33], 32'hA1);
        chk("mrst_w34", mem[34], 32'hA2);
        chk("mrst_w35", mem[35], 32'd0);
        chk("mrst_w39", mem[39], 32'd0);

        // Start during COPY is ignored
        mem_clear();
        poke(6'd0, 32'h5); poke(6'd1, 32'h6); poke(6'd8, 32'h77); poke(6'd9, 32'h88);
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.src = 32'h00; ifc.dst = 32'h80; ifc.len = 32'd2;
        @(posedge clk); #1;
        ndone = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) ifc.src = 32'h20;
            if (c == 2) ifc.start = 1'b0;
            if (ifc.done) ndone++;
            @(posedge clk); #1;
        end
        ifc.start = 1'b0;
        chk("busy_start_ndone", ndone, 32'd1);
        chk("busy_start_w32",   mem[32], 32'h5);
        chk("busy_start_w33",   mem[33], 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
